register_file: RTL and testbench

- 32-entry × 32-bit general-purpose register file for the MIPS CPU datapath.
- Two combinational read ports (rs, rt) and one synchronous write port (rd).
- Register 0 is hardwired to zero.
- Register 2 ($v0) is also exported on a dedicated debug/result output, register_v0.

---
 rtl/register_file.sv | 48 ++++
 tb/tb_register_file.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32 MIPS general-purpose register file: two combinational read ports, one
// synchronous write port, register 0 hardwired to zero, $v0 mirrored on register_v0.
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int V0_INDEX   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] rs_index,
   output logic [DATA_WIDTH-1:0] rs_data,
   input  logic [ADDR_WIDTH-1:0] rt_index,
   output logic [DATA_WIDTH-1:0] rt_data,
   input  logic [ADDR_WIDTH-1:0] rd_index,
   input  logic                  write_enable,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] register_v0
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            // $zero has no storage at all, so a write to index 0 simply has no target.
            assign w_regs[gi] = '0;
         end else begin : g_store
            logic [DATA_WIDTH-1:0] r_q;
            always_ff @(posedge clk or posedge reset) begin
               if (reset)
                  r_q <= '0;
               else if (write_enable && (rd_index == ADDR_WIDTH'(gi)))
                  r_q <= rd_data;
            end
            assign w_regs[gi] = r_q;
         end
      end
   endgenerate

   // Reads come straight from storage: no write-through, so a same-cycle write shows after the edge.
   assign rs_data     = w_regs[rs_index];
   assign rt_data     = w_regs[rt_index];
   assign register_v0 = w_regs[V0_INDEX];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by randomized
// traffic checked against an array model of the architectural registers.
module tb_register_file;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_index, rt_index, rd_index;
   logic        write_enable;
   logic [31:0] rd_data;
   logic [31:0] rs_data, rt_data, register_v0;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model [32];

   register_file dut (
      .clk(clk), .reset(reset),
      .rs_index(rs_index), .rs_data(rs_data),
      .rt_index(rt_index), .rt_data(rt_data),
      .rd_index(rd_index), .write_enable(write_enable), .rd_data(rd_data),
      .register_v0(register_v0)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] idx);
      return (idx == 5'd0) ? 32'd0 : model[idx];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
   endtask

   task automatic model_write(input logic we, input logic [4:0] idx, input logic [31:0] d);
      if (we && idx != 5'd0) model[idx] = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; rs_index = 5'd0; rt_index = 5'd31;
      write_enable = 1'b1; rd_index = 5'd31; rd_data = $urandom;
      tick();
      clear_model();
      n_cmp++; if (rs_data !== 32'd0) begin n_bad++; $display("FAIL reset_rs got=%h want=%h", rs_data, 32'd0); end
      n_cmp++; if (rt_data !== 32'd0) begin n_bad++; $display("FAIL reset_rt got=%h want=%h", rt_data, 32'd0); end
      n_cmp++; if (register_v0 !== 32'd0) begin n_bad++; $display("FAIL reset_v0 got=%h want=%h", register_v0, 32'd0); end
      $display("reset: rs=%h rt=%h v0=%h", rs_data, rt_data, register_v0);
      reset = 1'b0; write_enable = 1'b0;
   endtask

   task automatic test_basic_write();
      write_enable = 1'b1; rd_index = 5'd2; rd_data = 32'd32134; rs_index = 5'd2;
      #1;
      n_cmp++; if (rs_data !== 32'd0) begin n_bad++; $display("FAIL no_bypass got=%h want=%h", rs_data, 32'd0); end
      tick();
      model_write(1'b1, 5'd2, 32'd32134);
      n_cmp++; if (rs_data !== 32'd32134) begin n_bad++; $display("FAIL basic_rs got=%h want=%h", rs_data, 32'd32134); end
      n_cmp++; if (register_v0 !== 32'd32134) begin n_bad++; $display("FAIL basic_v0 got=%h want=%h", register_v0, 32'd32134); end
      $display("write r2=%0d: rs=%0d v0=%0d", 32134, rs_data, register_v0);
      write_enable = 1'b0;
   endtask

   task automatic test_reg_zero();
      write_enable = 1'b1; rd_index = 5'd0; rd_data = 32'd20; rt_index = 5'd0;
      tick();
      n_cmp++; if (rt_data !== 32'd0) begin n_bad++; $display("FAIL reg_zero got=%h want=%h", rt_data, 32'd0); end
      $display("write r0=20: rt=%0d", rt_data);
      write_enable = 1'b0;
   endtask

   task automatic test_we_gating();
      write_enable = 1'b0; rd_index = 5'd30; rd_data = 32'd1432; rs_index = 5'd30;
      tick();
      n_cmp++; if (rs_data !== 32'd0) begin n_bad++; $display("FAIL we_gating got=%h want=%h", rs_data, 32'd0); end
      $display("we=0 r30=1432: rs=%0d", rs_data);
   endtask

   task automatic test_dual_port_async_reset();
      write_enable = 1'b1; rd_index = 5'd5; rd_data = 32'hDEADBEEF;
      tick();
      model_write(1'b1, 5'd5, 32'hDEADBEEF);
      rd_index = 5'd31; rd_data = 32'h12345678;
      tick();
      model_write(1'b1, 5'd31, 32'h12345678);
      write_enable = 1'b0; rs_index = 5'd5; rt_index = 5'd31;
      #1;
      n_cmp++; if (rs_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dual_rs got=%h want=%h", rs_data, 32'hDEADBEEF); end
      n_cmp++; if (rt_data !== 32'h12345678) begin n_bad++; $display("FAIL dual_rt got=%h want=%h", rt_data, 32'h12345678); end
      $display("dual read: rs=%h rt=%h", rs_data, rt_data);
      // Mid-cycle, well clear of any clock edge.
      #1;
      reset = 1'b1;
      #1;
      clear_model();
      n_cmp++; if (rs_data !== 32'd0) begin n_bad++; $display("FAIL async_rs got=%h want=%h", rs_data, 32'd0); end
      n_cmp++; if (rt_data !== 32'd0) begin n_bad++; $display("FAIL async_rt got=%h want=%h", rt_data, 32'd0); end
      n_cmp++; if (register_v0 !== 32'd0) begin n_bad++; $display("FAIL async_v0 got=%h want=%h", register_v0, 32'd0); end
      $display("async reset: rs=%h rt=%h v0=%h", rs_data, rt_data, register_v0);
      reset = 1'b0;
   endtask

   task automatic test_full_sweep();
      logic [31:0] want;
      write_enable = 1'b1;
      for (int i = 1; i < 32; i++) begin
         rd_index = 5'(i); rd_data = 32'(i) * 32'h01010101;
         tick();
         model_write(1'b1, 5'(i), 32'(i) * 32'h01010101);
      end
      write_enable = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs_index = 5'(i); rt_index = 5'(i);
         #1;
         want = 32'(i) * 32'h01010101;
         n_cmp++; if (rs_data !== want) begin n_bad++; $display("FAIL sweep_rs[%0d] got=%h want=%h", i, rs_data, want); end
         n_cmp++; if (rt_data !== want) begin n_bad++; $display("FAIL sweep_rt[%0d] got=%h want=%h", i, rt_data, want); end
         $display("sweep idx=%0d: rs=%h rt=%h", i, rs_data, rt_data);
      end
      n_cmp++; if (register_v0 !== 32'h02020202) begin n_bad++; $display("FAIL sweep_v0 got=%h want=%h", register_v0, 32'h02020202); end
   endtask

   task automatic test_random();
      logic we_now;
      logic [4:0] rd_now;
      logic [31:0] d_now;
      for (int n = 0; n < 120; n++) begin
         we_now = 1'($urandom_range(0, 1));
         rd_now = 5'($urandom_range(0, 31));
         d_now  = $urandom;
         write_enable = we_now; rd_index = rd_now; rd_data = d_now;
         rs_index = ($urandom_range(0, 3) == 0) ? rd_now : 5'($urandom_range(0, 31));
         rt_index = ($urandom_range(0, 3) == 0) ? rs_index : 5'($urandom_range(0, 31));
         reset = ($urandom_range(0, 19) == 0);
         #1;
         if (reset) clear_model();
         n_cmp++; if (rs_data !== exp_rd(rs_index)) begin n_bad++; $display("FAIL rand_pre_rs n=%0d got=%h want=%h", n, rs_data, exp_rd(rs_index)); end
         n_cmp++; if (rt_data !== exp_rd(rt_index)) begin n_bad++; $display("FAIL rand_pre_rt n=%0d got=%h want=%h", n, rt_data, exp_rd(rt_index)); end
         tick();
         if (!reset) model_write(we_now, rd_now, d_now);
         n_cmp++; if (rs_data !== exp_rd(rs_index)) begin n_bad++; $display("FAIL rand_rs n=%0d got=%h want=%h", n, rs_data, exp_rd(rs_index)); end
         n_cmp++; if (rt_data !== exp_rd(rt_index)) begin n_bad++; $display("FAIL rand_rt n=%0d got=%h want=%h", n, rt_data, exp_rd(rt_index)); end
         n_cmp++; if (register_v0 !== model[2]) begin n_bad++; $display("FAIL rand_v0 n=%0d got=%h want=%h", n, register_v0, model[2]); end
         $display("rand %0d: rst=%0b we=%0b rd=%0d d=%h rs[%0d]=%h rt[%0d]=%h v0=%h",
                  n, reset, we_now, rd_now, d_now, rs_index, rs_data, rt_index, rt_data, register_v0);
         reset = 1'b0;
      end
      write_enable = 1'b0;
   endtask

   initial begin
      reset = 1'b1; write_enable = 1'b0;
      rs_index = '0; rt_index = '0; rd_index = '0; rd_data = '0;
      clear_model();
      test_reset();
      test_basic_write();
      test_reg_zero();
      test_we_gating();
      test_dual_port_async_reset();
      test_full_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
